// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_if
//  Description : Fetch-side and execute-side handshake bundle of the ALU
//                issue stage. The slave modport is the issue stage itself;
//                the master modport is the environment driving it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if #(
    parameter int XLEN = 32
);
    // Fetch side
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    // Execute side
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_ctrl;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [4:0]      out_rd;
    logic            out_wen;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, in_rs1_val, in_rs2_val, out_ready,
        output in_ready, out_valid, out_alu_ctrl, out_a, out_b, out_rd,
               out_wen, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, in_rs1_val, in_rs2_val, out_ready,
        input  in_ready, out_valid, out_alu_ctrl, out_a, out_b, out_rd,
               out_wen, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : RV32I integer-ALU issue stage. Decodes OP / OP-IMM / LUI /
//                AUIPC into ALU control plus operands and presents them
//                through a registered valid/ready output. Shift amounts are
//                masked here so the ALU never sees an amount above 31.
//                Optional macro ALU_ISSUE_SKID_EN adds a one-entry skid
//                buffer with a registered in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int XLEN = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_issue_if.slave  bus
);
    localparam logic [6:0] C_OPC_OP    = 7'b0110011;
    localparam logic [6:0] C_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] C_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] C_F7_BASE   = 7'b0000000;
    localparam logic [6:0] C_F7_ALT    = 7'b0100000;

    localparam logic [3:0] C_ALU_ADD   = 4'd0;
    localparam logic [3:0] C_ALU_SUB   = 4'd1;
    localparam logic [3:0] C_ALU_SLL   = 4'd2;
    localparam logic [3:0] C_ALU_LESS  = 4'd3;
    localparam logic [3:0] C_ALU_LESSU = 4'd4;
    localparam logic [3:0] C_ALU_XOR   = 4'd5;
    localparam logic [3:0] C_ALU_SRL   = 4'd6;
    localparam logic [3:0] C_ALU_SRA   = 4'd7;
    localparam logic [3:0] C_ALU_OR    = 4'd8;
    localparam logic [3:0] C_ALU_AND   = 4'd9;

    typedef struct packed {
        logic [3:0]      ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            wen;
        logic            illegal;
    } bundle_t;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_i_imm;
    logic [XLEN-1:0] w_u_imm;
    logic            w_legal;
    logic [3:0]      w_ctrl;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    bundle_t         w_dec;
    bundle_t         r_out;
    logic            r_out_valid;
    logic            w_in_ready;
    logic            w_in_xfer;
    logic            w_out_xfer;

    assign w_opcode = bus.in_inst[6:0];
    assign w_f3     = bus.in_inst[14:12];
    assign w_f7     = bus.in_inst[31:25];
    assign w_i_imm  = {{(XLEN-12){bus.in_inst[31]}}, bus.in_inst[31:20]};
    assign w_u_imm  = {bus.in_inst[31:12], 12'b0};

    // Instruction decode: ALU control, operand selection, shift masking
    always_comb begin
        w_legal = 1'b1;
        w_ctrl  = C_ALU_ADD;
        w_a     = '0;
        w_b     = '0;
        case (w_opcode)
            C_OPC_OP, C_OPC_OPIMM: begin
                w_a = bus.in_rs1_val;
                w_b = (w_opcode == C_OPC_OP) ? bus.in_rs2_val : w_i_imm;
                case (w_f3)
                    3'b000:  w_ctrl = (w_opcode == C_OPC_OP && w_f7[5]) ? C_ALU_SUB : C_ALU_ADD;
                    3'b001:  w_ctrl = C_ALU_SLL;
                    3'b010:  w_ctrl = C_ALU_LESS;
                    3'b011:  w_ctrl = C_ALU_LESSU;
                    3'b100:  w_ctrl = C_ALU_XOR;
                    3'b101:  w_ctrl = w_f7[5] ? C_ALU_SRA : C_ALU_SRL;
                    3'b110:  w_ctrl = C_ALU_OR;
                    default: w_ctrl = C_ALU_AND;
                endcase
                if (w_opcode == C_OPC_OP) begin
                    // Only the alternate funct7 forms SUB and SRA exist
                    if (w_f7 == C_F7_ALT)
                        w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
                    else
                        w_legal = (w_f7 == C_F7_BASE);
                end else if (w_f3 == 3'b001) begin
                    w_legal = (w_f7 == C_F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_legal = (w_f7 == C_F7_BASE) || (w_f7 == C_F7_ALT);
                end
            end
            C_OPC_LUI: begin
                w_b = w_u_imm;
            end
            C_OPC_AUIPC: begin
                w_a = bus.in_pc;
                w_b = w_u_imm;
            end
            default: w_legal = 1'b0;
        endcase
        // Shift amount is only the low five bits, for register and immediate forms
        if (w_ctrl == C_ALU_SLL || w_ctrl == C_ALU_SRL || w_ctrl == C_ALU_SRA)
            w_b = {{(XLEN-5){1'b0}}, w_b[4:0]};
        // Illegal encodings issue a harmless ADD 0,0 with no writeback
        if (!w_legal) begin
            w_ctrl = C_ALU_ADD;
            w_a    = '0;
            w_b    = '0;
        end
    end

    assign w_dec.ctrl    = w_ctrl;
    assign w_dec.a       = w_a;
    assign w_dec.b       = w_b;
    assign w_dec.rd      = bus.in_inst[11:7];
    assign w_dec.wen     = w_legal && (bus.in_inst[11:7] != 5'd0);
    assign w_dec.illegal = !w_legal;

    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t  r_state;
    bundle_t r_skid;
    logic    r_in_ready;

    // Output register plus skid entry; in_ready is a flop so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out       <= '0;
            r_skid      <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_out       <= w_dec;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_out <= w_dec;
                    end else if (w_in_xfer) begin
                        r_skid     <= w_dec;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        r_out      <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_BUSY;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_EMPTY;
                end
            endcase
        end
    end

    assign w_in_ready = r_in_ready;
`else
    // Single output register; a new bundle may enter whenever the current one leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out       <= w_dec;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign w_in_ready = !r_out_valid || bus.out_ready;
`endif

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_alu_ctrl = r_out.ctrl;
    assign bus.out_a        = r_out.a;
    assign bus.out_b        = r_out.b;
    assign bus.out_rd       = r_out.rd;
    assign bus.out_wen      = r_out.wen;
    assign bus.out_illegal  = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Self-checking bench for alu_issue. Table of instruction
//                vectors with hand-derived expected bundles, scoreboard queue
//                filled on input handshake and drained on output handshake,
//                plus backpressure and mid-stall reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
        logic [15:0] id;
    } exp_t;

`ifdef ALU_ISSUE_SKID_EN
    localparam int C_STALL_ACCEPTS = 2;
    localparam logic C_READY_AFTER_FIRST = 1'b1;
`else
    localparam int C_STALL_ACCEPTS = 1;
    localparam logic C_READY_AFTER_FIRST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if #(.XLEN(32)) bus ();

    alu_issue #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    exp_t sb[$];
    logic done_rand;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void add(logic [31:0] inst, logic [31:0] pc, logic [31:0] rs1,
                                logic [31:0] rs2, logic [3:0] ctrl, logic [31:0] a,
                                logic [31:0] b, logic [4:0] rd, logic wen, logic ill);
        vecs.push_back({inst, pc, rs1, rs2, ctrl, a, b, rd, wen, ill});
    endfunction

    function automatic exp_t to_exp(vec_t v, int id);
        exp_t e;
        e.ctrl = v.ctrl; e.a = v.a; e.b = v.b; e.rd = v.rd;
        e.wen = v.wen; e.ill = v.ill; e.id = id[15:0];
        return e;
    endfunction

    task automatic load(vec_t v);
        bus.in_inst    = v.inst;
        bus.in_pc      = v.pc;
        bus.in_rs1_val = v.rs1;
        bus.in_rs2_val = v.rs2;
    endtask

    // Drive one instruction until accepted; expected bundle is queued at the handshake
    task automatic send(vec_t v, int id, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        load(v);
        bus.in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                sb.push_back(to_exp(v, id));
            end
            @(posedge clk);
            #1;
            waits++;
            if (!acc && waits > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: id %0d not accepted after %0d cycles", id, waits);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    // Output monitor: scoreboard compare on output handshake, hold check while stalled
    logic        prev_stall = 1'b0;
    logic [75:0] prev_out;
    exp_t        e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if ({bus.out_valid, bus.out_alu_ctrl, bus.out_a, bus.out_b, bus.out_rd,
                     bus.out_wen, bus.out_illegal} !== prev_out) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h, expected %h",
                             {bus.out_valid, bus.out_alu_ctrl, bus.out_a, bus.out_b,
                              bus.out_rd, bus.out_wen, bus.out_illegal}, prev_out);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got bundle a=0x%08h, expected none", bus.out_a);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("ctrl[%0d]", e.id), 32'(bus.out_alu_ctrl), 32'(e.ctrl));
                    chk($sformatf("a[%0d]", e.id), bus.out_a, e.a);
                    chk($sformatf("b[%0d]", e.id), bus.out_b, e.b);
                    chk($sformatf("rd[%0d]", e.id), 32'(bus.out_rd), 32'(e.rd));
                    chk($sformatf("wen[%0d]", e.id), 32'(bus.out_wen), 32'(e.wen));
                    chk($sformatf("illegal[%0d]", e.id), 32'(bus.out_illegal), 32'(e.ill));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out = {bus.out_valid, bus.out_alu_ctrl, bus.out_a, bus.out_b, bus.out_rd,
                        bus.out_wen, bus.out_illegal};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   w;
        int   total;
        int   acc;
        int   idx;
        logic ir [3];

        //   inst          pc            rs1           rs2           ctrl a             b             rd wen ill
        add(32'h002081B3, 32'h00000100, 32'd5,        32'd7,        0, 32'd5,        32'd7,        3, 1, 0); // add x3,x1,x2
        add(32'h40435293, 32'h00000104, 32'h80000000, 32'h12345678, 7, 32'h80000000, 32'd4,        5, 1, 0); // srai x5,x6,4
        add(32'h009413B3, 32'h00000108, 32'd1,        32'hFFFFFF21, 2, 32'd1,        32'd1,        7, 1, 0); // sll x7,x8,x9
        add(32'h12345097, 32'h80000010, 32'h0000DEAD, 32'h0000BEEF, 0, 32'h80000010, 32'h12345000, 1, 1, 0); // auipc
        add(32'h00002083, 32'h00000110, 32'h00001111, 32'h00002222, 0, 32'd0,        32'd0,        1, 0, 1); // lw
        add(32'h00100013, 32'h00000114, 32'd0,        32'd0,        0, 32'd0,        32'd1,        0, 0, 0); // addi x0,x0,1
        add(32'h40C58533, 32'h00000118, 32'd10,       32'd3,        1, 32'd10,       32'd3,       10, 1, 0); // sub
        add(32'hFFF2A213, 32'h0000011C, 32'd7,        32'd0,        3, 32'd7,        32'hFFFFFFFF, 4, 1, 0); // slti -1
        add(32'h4083D333, 32'h00000120, 32'hF0000000, 32'h00000023, 7, 32'hF0000000, 32'd3,        6, 1, 0); // sra
        add(32'h7FF0C493, 32'h00000124, 32'h0F0F0F0F, 32'd0,        5, 32'h0F0F0F0F, 32'h000007FF, 9, 1, 0); // xori
        add(32'hABCDE137, 32'h00000128, 32'h00000099, 32'd0,        0, 32'd0,        32'hABCDE000, 2, 1, 0); // lui
        add(32'h023100B3, 32'h0000012C, 32'd4,        32'd5,        0, 32'd0,        32'd0,        1, 0, 1); // mul
        add(32'h403170B3, 32'h00000130, 32'd4,        32'd5,        0, 32'd0,        32'd0,        1, 0, 1); // OP f7=0100000 f3=111
        add(32'h40311093, 32'h00000134, 32'd4,        32'd5,        0, 32'd0,        32'd0,        1, 0, 1); // slli bad imm[11:5]
        add(32'h01F15093, 32'h00000138, 32'h80000000, 32'd0,        6, 32'h80000000, 32'd31,       1, 1, 0); // srli 31
        add(32'hFF027193, 32'h0000013C, 32'h12345678, 32'd0,        9, 32'h12345678, 32'hFFFFFFF0, 3, 1, 0); // andi -16
        add(32'h005231B3, 32'h00000140, 32'd1,        32'd2,        4, 32'd1,        32'd2,        3, 1, 0); // sltu
        add(32'h005261B3, 32'h00000144, 32'h000000F0, 32'h0000000F, 8, 32'h000000F0, 32'h0000000F, 3, 1, 0); // or
        add(32'h80010093, 32'h00000148, 32'd100,      32'd0,        0, 32'd100,      32'hFFFFF800, 1, 1, 0); // addi -2048

        bus.in_valid   = 1'b0;
        bus.in_inst    = '0;
        bus.in_pc      = '0;
        bus.in_rs1_val = '0;
        bus.in_rs2_val = '0;
        bus.out_ready  = 1'b1;
        done_rand      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_ctrl", 32'(bus.out_alu_ctrl), 0);
        chk("rst_a", bus.out_a, 0);
        chk("rst_b", bus.out_b, 0);
        chk("rst_rd", 32'(bus.out_rd), 0);
        chk("rst_wen", 32'(bus.out_wen), 0);
        chk("rst_illegal", 32'(bus.out_illegal), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back table pass with the sink always ready
        total = 0;
        foreach (vecs[i]) begin
            send(vecs[i], i, w);
            total += w;
        end
        chk("throughput_cycles", total, vecs.size());
        drain();

        // Table pass with random sink backpressure
        fork
            begin
                foreach (vecs[i]) send(vecs[i], 100 + i, w);
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Stall for three cycles while offering three instructions
        bus.out_ready = 1'b0;
        acc = 0;
        idx = 0;
        load(vecs[0]);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ir[c] = bus.in_ready;
            if (bus.in_ready) begin
                sb.push_back(to_exp(vecs[idx], 200 + idx));
                acc++;
                idx++;
            end
            @(posedge clk);
            #1;
            load(vecs[idx]);
        end
        chk("stall_accepts", acc, C_STALL_ACCEPTS);
        chk("stall_ready_c1", 32'(ir[1]), 32'(C_READY_AFTER_FIRST));
        chk("stall_ready_c2", 32'(ir[2]), 0);
        chk("stall_out_valid", 32'(bus.out_valid), 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset asserted in the middle of a stall drops the held bundle at once
        bus.out_ready = 1'b0;
        send(vecs[3], 300, w);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        chk("midrst_a", bus.out_a, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(vecs[0], 400, w);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

Decode-to-execute issue stage for the NPC core. It accepts one RV32I instruction per handshake from the fetch side, together with its PC and the two register-file read values. It decodes the integer ALU subset into the 4-bit ALU control code and the two 32-bit ALU operands, and presents them through a registered valid/ready output to the execute stage. This block is the driving end of the ALU's `alu_ctrl`/`a`/`b` interface. It owns all operand selection and shift-amount masking, so the ALU stays purely combinational.

## Interface
- `XLEN`, default 32: datapath width; only 32 is supported.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream holds a valid instruction.
- `in_ready` output 1: stage can accept this cycle.
- `in_inst` input 32: instruction word.
- `in_pc` input 32: instruction PC.
- `in_rs1_val` input 32: GPR[rs1] value.
- `in_rs2_val` input 32: GPR[rs2] value.
- `out_valid` output 1: issue bundle valid.
- `out_ready` input 1: execute stage accepts the bundle.
- `out_alu_ctrl` output 4: ALU opcode, encoded as ADD=0, SUB=1, SLL=2, LESS=3, LESSU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- `out_a` output 32: ALU operand a.
- `out_b` output 32: ALU operand b.
- `out_rd` output 5: destination register.
- `out_wen` output 1: register writeback enable.
- `out_illegal` output 1: instruction is outside the decoded subset.

## Operation
- Transfers:
  - An input transfer happens when `in_valid && in_ready`.
  - An output transfer happens when `out_valid && out_ready`.
- Decode by opcode `inst[6:0]`:
  - OP (0110011): a=rs1_val, b=rs2_val. Control from funct3/funct7[5]: 000/0 ADD, 000/1 SUB, 001 SLL, 010 LESS, 011 LESSU, 100 XOR, 101/0 SRL, 101/1 SRA, 110 OR, 111 AND.
  - OP-IMM (0010011): a=rs1_val, b=sign-extended I-immediate. Same funct3 mapping, except 000 is always ADD and funct7[5] selects SRA for 101.
  - LUI (0110111): a=0, b={inst[31:12],12'b0}, ADD.
  - AUIPC (0010111): a=pc, b={inst[31:12],12'b0}, ADD.
- Shift masking: for SLL/SRL/SRA, b is zero-extended `b[4:0]` (for both register and immediate shifts). The ALU is never given a shift amount above 31.
- Illegal encodings:
  - Covers any other opcode, OP with funct7 not in {0000000, 0100000}, OP with funct7=0100000 and funct3 not in {000, 101}, and OP-IMM shifts with a bad imm[11:5].
  - Response: illegal=1, wen=0, ctrl=ADD, a=b=0, rd=inst[11:7].
- `out_wen` = legal && rd≠0.
- All outputs are registered; no combinational path from `in_*` to `out_*`.

## Timing
- Reset, asynchronous on `rst_n` low:
  - `out_valid`=0, `in_ready`=1, `out_alu_ctrl`=ADD(0), `out_a`=`out_b`=0, `out_rd`=0, `out_wen`=0, `out_illegal`=0.
  - Skid entry is cleared.
  - Asserting reset mid-handshake drops in-flight bundles; nothing is replayed.
- Latency: a bundle accepted at edge N is on `out_*` with `out_valid`=1 after edge N.
- While `out_valid`=1 and `out_ready`=0, all `out_*` hold stable.
- Throughput is one bundle per cycle when `out_ready` stays high.
- Simultaneous input and output transfer in one cycle: the output register loads the new bundle; `out_valid` stays 1.

## Configuration
- Macro `ALU_ISSUE_SKID_EN`.
- Defined:
  - Adds a one-entry skid buffer and makes `in_ready` a flop output, so there is no combinational `out_ready` to `in_ready` path.
  - States:
    - EMPTY: out invalid, in_ready=1.
    - BUSY: out valid, skid empty, in_ready=1.
    - FULL: out and skid valid, in_ready=0.
  - Transitions:
    - EMPTY + in → BUSY.
    - BUSY + in and no out → FULL.
    - BUSY + out and no in → EMPTY.
    - FULL + out → BUSY, with the skid moving to the output.
  - Ordering is strictly FIFO.
- Undefined:
  - Output register only.
  - `in_ready` = !`out_valid` || `out_ready` (combinational).
  - Reset value of `in_ready` is 1 in both builds.

## Test plan
- Issue `add x3,x1,x2` (0x002081B3) with rs1=5, rs2=7. Expected next cycle: ctrl=0, a=5, b=7, rd=3, wen=1, illegal=0.
- Issue `srai x5,x6,4` (0x40435293) with rs1=0x80000000. Expected: ctrl=7, a=0x80000000, b=4.
- Issue `sll` with rs2=0xFFFFFF21. Expected: b=1.
- Issue `auipc x1,0x12345` at pc=0x80000010. Expected: ctrl=0, a=0x80000010, b=0x12345000.
- Issue a load opcode 0x00002083. Expected: illegal=1, wen=0, a=b=0.
- Issue `addi x0,x0,1`. Expected: wen=0.
- Backpressure: hold `out_ready`=0 for 3 cycles while streaming 3 instructions.
  - Skid build: accepts exactly 2, and `in_ready` falls the cycle after the second accept.
  - Non-skid build: accepts 1.
  - All builds: outputs stay stable while stalled, and order is preserved on release.
  - Assert `rst_n`=0 mid-stall: `out_valid` drops to 0 immediately.
